dlsc_demosaic_vng6_div: RTL

DLSC_DEMOSAIC_VNG6_DIV -- requirements
Module: dlsc_demosaic_vng6_div

---
 rtl/dlsc_demosaic_vng6_div.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/dlsc_demosaic_vng6_div.sv
// VNG demosaic final stage: divides the colour-difference sums by the neighbour count
// with two serial restoring dividers, then adds the result to the centre pixel with saturation.
module dlsc_demosaic_vng6_div #(
  parameter int DATA = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clk_en,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DATA+3:0] in_sum_red,
  input  logic [DATA+3:0] in_sum_green,
  input  logic [DATA+3:0] in_sum_blue,
  input  logic [3:0]      in_sum_cnt,
  input  logic [DATA-1:0] in_center,
  input  logic [1:0]      in_color,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DATA-1:0] out_red,
  output logic [DATA-1:0] out_green,
  output logic [DATA-1:0] out_blue
);

  localparam int SW = DATA + 4;
  localparam int DW = DATA + 5;
  localparam int IW = $clog2(DATA + 4);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_iter;
  logic [SW-1:0]   r_qa, r_qb;
  logic [3:0]      r_rema, r_remb;
  logic            r_nega, r_negb;
  logic [3:0]      r_cnt;
  logic [DATA-1:0] r_center;
  logic [1:0]      r_color;

  logic [1:0]      w_color;
  logic [SW-1:0]   w_sum_c, w_sum_a, w_sum_b;
  logic [DW-1:0]   w_da, w_db;
  logic [SW-1:0]   w_abs_a, w_abs_b;
  logic [SW+3:0]   w_step_a, w_step_b;
  logic [DATA-1:0] w_fix_a, w_fix_b;

  // One restoring step: returns {remainder, shifted dividend/quotient}
  function automatic logic [SW+3:0] div_step(input logic [3:0] rem, input logic [SW-1:0] q,
                                             input logic [3:0] dvs);
    logic [4:0] trial;
    logic [4:0] diff;
    trial = {rem, q[SW-1]};
    diff  = trial - {1'b0, dvs};
    if (trial >= {1'b0, dvs}) div_step = {diff[3:0], q[SW-2:0], 1'b1};
    else                      div_step = {trial[3:0], q[SW-2:0], 1'b0};
  endfunction

  function automatic logic [DATA-1:0] fix_chan(input logic neg, input logic [SW-1:0] q,
                                               input logic [DATA-1:0] ctr);
    logic signed [DATA+5:0] s;
    logic signed [DATA+5:0] sq;
    sq = $signed({2'b00, q});
    s  = $signed({6'b000000, ctr}) + (neg ? -sq : sq);
    if (s[DATA+5])           fix_chan = '0;
    else if (|s[DATA+4:DATA]) fix_chan = '1;
    else                     fix_chan = s[DATA-1:0];
  endfunction

  // Channel A/B are the two non-centre channels in R,G,B order
  always_comb begin
    w_color = (in_color == 2'd3) ? 2'd1 : in_color;
    w_sum_c = in_sum_green;
    w_sum_a = in_sum_red;
    w_sum_b = in_sum_blue;
    case (w_color)
      2'd0: begin w_sum_c = in_sum_red;  w_sum_a = in_sum_green; w_sum_b = in_sum_blue;  end
      2'd2: begin w_sum_c = in_sum_blue; w_sum_a = in_sum_red;   w_sum_b = in_sum_green; end
      default: ;
    endcase
    w_da    = {1'b0, w_sum_a} - {1'b0, w_sum_c};
    w_db    = {1'b0, w_sum_b} - {1'b0, w_sum_c};
    w_abs_a = w_da[DW-1] ? SW'(-w_da) : w_da[SW-1:0];
    w_abs_b = w_db[DW-1] ? SW'(-w_db) : w_db[SW-1:0];
    w_step_a = div_step(r_rema, r_qa, r_cnt);
    w_step_b = div_step(r_remb, r_qb, r_cnt);
    w_fix_a  = fix_chan(r_nega, r_qa, r_center);
    w_fix_b  = fix_chan(r_negb, r_qb, r_center);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_state_nxt = (in_sum_cnt == 4'd0) ? S_FIX : S_DIV;
      S_DIV:  if (r_iter == '0) w_state_nxt = S_FIX;
      S_FIX:  w_state_nxt = S_DONE;
      S_DONE: if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_iter    <= '0;
      r_qa      <= '0;
      r_qb      <= '0;
      r_rema    <= '0;
      r_remb    <= '0;
      r_nega    <= 1'b0;
      r_negb    <= 1'b0;
      r_cnt     <= '0;
      r_center  <= '0;
      r_color   <= '0;
      out_red   <= '0;
      out_green <= '0;
      out_blue  <= '0;
    end else if (clk_en) begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_iter   <= IW'(DATA + 3);
          r_qa     <= w_abs_a;
          r_qb     <= w_abs_b;
          r_rema   <= '0;
          r_remb   <= '0;
          r_nega   <= w_da[DW-1];
          r_negb   <= w_db[DW-1];
          r_cnt    <= in_sum_cnt;
          r_center <= in_center;
          r_color  <= w_color;
        end
        S_DIV: begin
          r_iter <= r_iter - 1'b1;
          {r_rema, r_qa} <= w_step_a;
          {r_remb, r_qb} <= w_step_b;
        end
        S_FIX: begin
          if (r_cnt == 4'd0) begin
            out_red   <= r_center;
            out_green <= r_center;
            out_blue  <= r_center;
          end else begin
            case (r_color)
              2'd0:    begin out_red <= r_center; out_green <= w_fix_a;  out_blue <= w_fix_b;  end
              2'd2:    begin out_red <= w_fix_a;  out_green <= w_fix_b;  out_blue <= r_center; end
              default: begin out_red <= w_fix_a;  out_green <= r_center; out_blue <= w_fix_b;  end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule
